// File: rtl/arith_pkg.sv
// Shared opcode encodings and opcode bit positions for the arithmetic pipe.
package arith_pkg;
   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_ADDC  = 3'b001;
   localparam logic [2:0] OP_ADDN  = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_PASS  = 3'b100;
   localparam logic [2:0] OP_INC   = 3'b101;
   localparam logic [2:0] OP_DEC   = 3'b110;
   localparam logic [2:0] OP_PASSC = 3'b111;

   localparam int OPB_ZERO = 2;
   localparam int OPB_INV  = 1;
   localparam int OPB_CI   = 0;
endpackage

// File: rtl/arith_pipe_unit_if.sv
// Operand/result handshake bundle between operand fetch and the accumulator stage.
interface arith_pipe_unit_if #(parameter int N = 16);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [2:0]   opcode;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] y;
   logic         co;
   logic         ovf;
   logic         zero;

   modport master (output in_valid, a, b, opcode, out_ready,
                   input  in_ready, out_valid, y, co, ovf, zero);
   modport slave  (input  in_valid, a, b, opcode, out_ready,
                   output in_ready, out_valid, y, co, ovf, zero);
endinterface

// File: rtl/arith_seg_adder.sv
// One W-bit slice of the segmented carry chain; sum and carry-out are registered.
module arith_seg_adder #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] sum,
   output logic         co
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
         co  <= 1'b0;
      end else if (en) begin
         {co, sum} <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      end
   end
endmodule

// File: rtl/arith_pipe_unit.sv
// Carry-segmented add/sub pipe with valid/ready backpressure and status flags.
// Define ARITH_PIPE_SAT_EN to saturate y on signed overflow.
module arith_pipe_unit
   import arith_pkg::*;
#(
   parameter int N    = 16,
   parameter int SEGS = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   arith_pipe_unit_if.slave bus
);
   localparam int W   = N / SEGS;
   localparam int LAT = SEGS + 1;

   if (N < 2 || SEGS < 1 || (N % SEGS) != 0) begin : g_bad_cfg
      $error("arith_pipe_unit: N must be >= 2 and a multiple of SEGS");
   end

   logic           adv;
   logic [LAT-1:0] vld_pipe;
   logic [N-1:0]   bm;
   logic [N-1:0]   a_p [SEGS+1];
   logic [N-1:0]   b_p [SEGS+1];
   logic           ci0;
   logic [SEGS:0]  cy;
   logic [N-1:0]   res [SEGS];
   logic [N-1:0]   y_raw;
   logic           sa, sb;

   assign adv          = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv;

   always_comb begin
      bm = bus.opcode[OPB_ZERO] ? '0 : bus.b;
      if (bus.opcode[OPB_INV]) bm = ~bm;
   end

   // Operands ride the whole pipe so each segment sees its slice and the
   // output stage still has the sign bits for overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         ci0      <= 1'b0;
         for (int k = 0; k <= SEGS; k++) begin
            a_p[k] <= '0;
            b_p[k] <= '0;
         end
      end else if (adv) begin
         vld_pipe <= {vld_pipe[LAT-2:0], bus.in_valid};
         ci0      <= bus.opcode[OPB_CI];
         a_p[0]   <= bus.a;
         b_p[0]   <= bm;
         for (int k = 1; k <= SEGS; k++) begin
            a_p[k] <= a_p[k-1];
            b_p[k] <= b_p[k-1];
         end
      end
   end

   assign cy[0] = ci0;

   for (genvar j = 0; j < SEGS; j++) begin : g_seg
      logic [W-1:0] sum;

      arith_seg_adder #(.W(W)) u_seg (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (adv),
         .a     (a_p[j][j*W +: W]),
         .b     (b_p[j][j*W +: W]),
         .ci    (cy[j]),
         .sum   (sum),
         .co    (cy[j+1])
      );

      if (j == 0) begin : g_first
         assign res[0] = N'(sum);
      end else begin : g_rest
         // Lower slices finished in earlier stages, carried forward alongside.
         logic [N-1:0] lo;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   lo <= '0;
            else if (adv) lo <= res[j-1];
         end
         assign res[j] = lo | (N'(sum) << (j*W));
      end
   end

   assign y_raw         = res[SEGS-1];
   assign sa            = a_p[SEGS][N-1];
   assign sb            = b_p[SEGS][N-1];
   assign bus.out_valid = vld_pipe[LAT-1];
   assign bus.co        = bus.out_valid & cy[SEGS];
   assign bus.ovf       = bus.out_valid & (sa == sb) & (y_raw[N-1] != sa);

`ifdef ARITH_PIPE_SAT_EN
   assign bus.y = bus.ovf ? {sa, {(N-1){~sa}}} : y_raw;
`else
   assign bus.y = y_raw;
`endif

   assign bus.zero = bus.out_valid & ~|bus.y;
endmodule

// File: tb/tb_arith_pipe_unit.sv
// Scoreboard bench for arith_pipe_unit (N=16, SEGS=4); honours ARITH_PIPE_SAT_EN.
module tb_arith_pipe_unit;
   import arith_pkg::*;

   localparam int N    = 16;
   localparam int SEGS = 4;
   localparam int LAT  = SEGS + 1;

   typedef struct packed {
      logic [N-1:0] y;
      logic         co;
      logic         ovf;
      logic         zero;
      logic         lat_chk;
      logic [31:0]  t;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   arith_pipe_unit_if #(.N(N)) bus ();

   arith_pipe_unit #(.N(N), .SEGS(SEGS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t        sb_q [$];
   exp_t        mon_e;
   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] cyc   = 0;
   bit          lat_on = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic [2:0] op);
      exp_t         e;
      logic [N-1:0] bm;
      logic         ci;
      logic [N:0]   s;
      case (op)
         OP_ADD:   begin bm = b;    ci = 1'b0; end
         OP_ADDC:  begin bm = b;    ci = 1'b1; end
         OP_ADDN:  begin bm = ~b;   ci = 1'b0; end
         OP_SUB:   begin bm = ~b;   ci = 1'b1; end
         OP_PASS:  begin bm = '0;   ci = 1'b0; end
         OP_INC:   begin bm = '0;   ci = 1'b1; end
         OP_DEC:   begin bm = '1;   ci = 1'b0; end
         default:  begin bm = '1;   ci = 1'b1; end
      endcase
      s     = {1'b0, a} + {1'b0, bm} + {{N{1'b0}}, ci};
      e.y   = s[N-1:0];
      e.co  = s[N];
      e.ovf = (a[N-1] == bm[N-1]) && (e.y[N-1] != a[N-1]);
`ifdef ARITH_PIPE_SAT_EN
      if (e.ovf) e.y = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
      e.zero    = (e.y == '0);
      e.lat_chk = 1'b0;
      e.t       = '0;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Retire before accept so a same-cycle push never satisfies its own pop.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               check("spurious_out", 32'(bus.y), 32'hDEAD);
            end else begin
               mon_e = sb_q.pop_front();
               check("y",    32'(bus.y),    32'(mon_e.y));
               check("co",   32'(bus.co),   32'(mon_e.co));
               check("ovf",  32'(bus.ovf),  32'(mon_e.ovf));
               check("zero", 32'(bus.zero), 32'(mon_e.zero));
               if (mon_e.lat_chk) check("latency", cyc - mon_e.t, LAT);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            mon_e         = model(bus.a, bus.b, bus.opcode);
            mon_e.lat_chk = lat_on;
            mon_e.t       = cyc;
            sb_q.push_back(mon_e);
         end
      end
   end

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
      int   n = 0;
      logic acc;
      bus.a        = a;
      bus.b        = b;
      bus.opcode   = op;
      bus.in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) check("send_timeout", 32'(acc), 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain", sb_q.size(), 0);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.opcode    = OP_ADD;
      bus.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_y",         32'(bus.y),         0);
      check("rst_co",        32'(bus.co),        0);
      check("rst_ovf",       32'(bus.ovf),       0);
      check("rst_zero",      32'(bus.zero),      0);
      check("rst_in_ready",  32'(bus.in_ready),  1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // single beat, latency
      lat_on = 1'b1;
      send(16'h0003, 16'h0005, OP_ADD);
      drain();

      // back-to-back subtract to zero
      for (int i = 0; i < 8; i++) send(N'(i), N'(i), OP_SUB);
      drain();

      // overflow, cross-segment carry, opcode corners
      send(16'h7FFF, 16'h0001, OP_ADD);
      send(16'h0FFF, 16'h0001, OP_ADD);
      send(16'hFFFF, 16'h1234, OP_PASSC);
      send(16'h8000, 16'h0001, OP_SUB);
      send(16'h1234, 16'h0F0F, OP_ADDN);
      send(16'hFFFF, 16'h0000, OP_ADDC);
      send(16'h7FFF, 16'hAAAA, OP_INC);
      send(16'h0000, 16'h5555, OP_DEC);
      send(16'h8000, 16'h7777, OP_PASS);
      send(16'h8000, 16'h8000, OP_ADD);
      drain();

      // backpressure: 3-cycle stall while a beat is waiting to enter
      lat_on = 1'b0;
      fork
         for (int i = 0; i < 6; i++) send(N'(16'h0100 + i), N'(i * 3), 3'(i % 8));
         begin
            repeat (5) @(posedge clk);
            for (int s = 0; s < 3; s++) begin
               #1 bus.out_ready = 1'b0;
               #1 check("stall_in_ready", 32'(bus.in_ready), 0);
               @(posedge clk);
            end
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();

      // random operands with random backpressure
      fork
         for (int i = 0; i < 24; i++) send(N'($urandom), N'($urandom), 3'($urandom_range(0, 7)));
         begin
            for (int s = 0; s < 40; s++) begin
               @(posedge clk);
               #1 bus.out_ready = 1'($urandom_range(0, 1));
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // reset with beats in flight
      for (int i = 0; i < 3; i++) send(N'(16'h0040 + i), 16'h0001, OP_ADD);
      repeat (2) @(posedge clk);
      #2;
      check("pre_rst_valid", 32'(bus.out_valid), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(bus.out_valid), 0);
      check("mid_rst_y",         32'(bus.y),         0);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("post_rst_idle", 32'(bus.out_valid), 0);

      lat_on = 1'b1;
      send(16'h0010, 16'h0020, OP_ADD);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
